// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module rv_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iStart,
    input  logic [2:0]      iFunct3,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iB,
    output logic            oBusy,
    output logic            oDone,
    output logic [XLEN-1:0] oResult
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t              state_r, state_nx;
    logic [2:0]          funct3_r;
    logic [XLEN-1:0]     a_mag_r, b_mag_r;
    logic                neg_q_r, neg_r_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [XLEN-1:0]     result_r;
    logic                done_r;

    // Operand decode at the sampling edge
    logic                is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf, fast;
    logic [2*XLEN-1:0]   fast_acc;

    always_comb begin
        is_div   = iFunct3[2];
        a_sgn    = is_div ? ~iFunct3[0] : (iFunct3[1] ^ iFunct3[0]);
        b_sgn    = is_div ? ~iFunct3[0] : (iFunct3[1:0] == 2'b01);
        a_neg    = a_sgn & iA[XLEN-1];
        b_neg    = b_sgn & iB[XLEN-1];
        a_mag    = a_neg ? -iA : iA;
        b_mag    = b_neg ? -iB : iB;
        div_zero = is_div && (iB == '0);
        div_ovf  = is_div && !iFunct3[0] && (iA == MOST_NEG) && (iB == '1);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] ext_a, ext_b, mul_full;
    always_comb begin
        ext_a    = {{XLEN{a_sgn & iA[XLEN-1]}}, iA};
        ext_b    = {{XLEN{b_sgn & iB[XLEN-1]}}, iB};
        mul_full = ext_a * ext_b;
    end
    assign fast = div_zero | div_ovf | !is_div;
`else
    assign fast = div_zero | div_ovf;
`endif

    // Fast-path results are preloaded so FIX selects them with no sign fix
    always_comb begin
        fast_acc = {{XLEN{1'b0}}, iA};
        if (div_zero)
            fast_acc = {iA, {XLEN{1'b1}}};
        else if (div_ovf)
            fast_acc = {{XLEN{1'b0}}, iA};
`ifdef MULDIV_FAST_MUL_EN
        else
            fast_acc = mul_full;
`endif
    end

    // One radix-2 step of either algorithm
    logic [XLEN-1:0]   acc_hi, acc_lo, mul_addend;
    logic [XLEN:0]     mul_sum, div_shl;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] step_nx;

    always_comb begin
        acc_hi     = acc_r[2*XLEN-1:XLEN];
        acc_lo     = acc_r[XLEN-1:0];
        mul_addend = acc_lo[0] ? a_mag_r : '0;
        mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};
        div_shl    = {acc_hi, acc_lo[XLEN-1]};
        div_diff   = {1'b0, div_shl} - {2'b00, b_mag_r};
        if (!funct3_r[2])
            step_nx = {mul_sum, acc_lo[XLEN-1:1]};
        else if (div_diff[XLEN+1])
            step_nx = {div_shl[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
        else
            step_nx = {div_diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
    end

    // Sign correction and result select
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = neg_q_r ? -acc_r : acc_r;
        quo  = neg_q_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
        rem  = neg_r_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
        case (funct3_r)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            state_r <= IDLE;
        else
            state_r <= state_nx;
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (iStart) state_nx = fast ? FIX : CALC;
            CALC:    if (cnt_r == CNT_W'(1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            funct3_r <= '0;
            a_mag_r  <= '0;
            b_mag_r  <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            acc_r    <= '0;
            cnt_r    <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: if (iStart) begin
                    funct3_r <= iFunct3;
                    a_mag_r  <= a_mag;
                    b_mag_r  <= b_mag;
                    cnt_r    <= CNT_W'(XLEN);
                    if (fast) begin
                        acc_r   <= fast_acc;
                        neg_q_r <= 1'b0;
                        neg_r_r <= 1'b0;
                    end else begin
                        acc_r   <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                        neg_q_r <= a_neg ^ b_neg;
                        neg_r_r <= a_neg;
                    end
                end
                CALC: begin
                    acc_r <= step_nx;
                    cnt_r <= cnt_r - 1'b1;
                end
                FIX: begin
                    result_r <= fix_res;
                    done_r   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign oBusy   = (state_r != IDLE);
    assign oDone   = done_r;
    assign oResult = result_r;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed, table-driven bench for rv_muldiv_unit (XLEN=32).
module tb_rv_muldiv_unit;

    localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic            iClk = 1'b0;
    logic            iRst = 1'b1;
    logic            iStart = 1'b0;
    logic [2:0]      iFunct3 = '0;
    logic [XLEN-1:0] iA = '0;
    logic [XLEN-1:0] iB = '0;
    logic            oBusy, oDone;
    logic [XLEN-1:0] oResult;

    rv_muldiv_unit #(.XLEN(XLEN)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iFunct3(iFunct3),
        .iA(iA), .iB(iB), .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        string           name;
        logic [2:0]      f;
        logic [XLEN-1:0] a, b, res;
        int              lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called #1 after an edge; that edge's successor is the sampling edge E0
    task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        iFunct3 = f; iA = a; iB = b; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0; iFunct3 = 3'($urandom); iA = $urandom; iB = $urandom;
    endtask

    task automatic wait_done(input int budget, output int lat, output bit busy_ok);
        lat = 0; busy_ok = 1'b1;
        while (!oDone && lat < budget) begin
            if (!oBusy) busy_ok = 1'b0;
            @(posedge iClk); #1;
            lat++;
        end
    endtask

    task automatic finish_op(input string name, input logic [XLEN-1:0] res, input int lat_exp, input int lat_base);
        int lat; bit busy_ok;
        wait_done(64, lat, busy_ok);
        check({name, " done"}, 32'(oDone), 32'd1);
        check({name, " result"}, oResult, res);
        check({name, " latency"}, 32'(lat + lat_base), 32'(lat_exp));
        check({name, " busy during op"}, 32'(busy_ok), 32'd1);
        check({name, " busy low at done"}, 32'(oBusy), 32'd0);
    endtask

    vec_t vecs[16];

    initial begin
        int lat; bit busy_ok; bit saw_done;
        vecs[0]  = '{"mul 7*-3",       3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
        vecs[1]  = '{"mulh min*min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
        vecs[2]  = '{"mulhu max*max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        vecs[3]  = '{"mulhsu -1*2",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT};
        vecs[4]  = '{"div -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT};
        vecs[5]  = '{"rem -7/2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT};
        vecs[6]  = '{"divu 100/7",     3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT};
        vecs[7]  = '{"remu 100/7",     3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT};
        vecs[8]  = '{"divu 5/0",       3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{"remu 5/0",       3'b111, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{"div ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{"rem ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[12] = '{"mul by 0",       3'b000, 32'h12345678, 32'd0,        32'd0,        MUL_LAT};
        vecs[13] = '{"div 0/5",        3'b100, 32'd0,        32'd5,        32'd0,        DIV_LAT};
        vecs[14] = '{"rem 7/-2",       3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT};
        vecs[15] = '{"div -8/0",       3'b100, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFFF, 1};

        #2;
        check("reset busy", 32'(oBusy), 32'd0);
        check("reset done", 32'(oDone), 32'd0);
        check("reset result", oResult, 32'd0);
        repeat (2) @(posedge iClk);
        #1 iRst = 1'b0;
        @(posedge iClk); #1;

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            finish_op(vecs[i].name, vecs[i].res, vecs[i].lat, 0);
            @(posedge iClk); #1;
            check({vecs[i].name, " done pulse"}, 32'(oDone), 32'd0);
            check({vecs[i].name, " hold"}, oResult, vecs[i].res);
        end

        // iStart during busy is ignored; a start in the oDone cycle is taken
        issue(3'b101, 32'd100, 32'd7);
        repeat (4) @(posedge iClk);
        #1;
        iFunct3 = 3'b000; iA = 32'd3; iB = 32'd3; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        finish_op("busy ignore", 32'd14, DIV_LAT, 5);
        issue(3'b000, 32'd3, 32'd3);
        finish_op("start at done", 32'd9, MUL_LAT, 0);

        // Reset mid-operation aborts without oDone
        @(posedge iClk); #1;
        issue(3'b100, 32'd100, 32'd7);
        repeat (9) @(posedge iClk);
        #1 iRst = 1'b1;
        #1;
        check("abort busy", 32'(oBusy), 32'd0);
        check("abort done", 32'(oDone), 32'd0);
        check("abort result", oResult, 32'd0);
        @(posedge iClk); #1 iRst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge iClk); #1;
            if (oDone || oBusy) saw_done = 1'b1;
        end
        check("abort no done", 32'(saw_done), 32'd0);
        issue(3'b000, 32'd6, 32'd7);
        finish_op("mul after reset", 32'd42, MUL_LAT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit, parametrised in operand width. It sits beside the RV32I ALU in the datapath and executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. Control uses a start/busy/done handshake. Control stalls the PC and register-file write while oBusy is high.

Parameters:
XLEN, 32, operand/result width in bits (≥4, even).
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
iClk  input  1  clock; all state updates on rising edge
iRst  input  1  asynchronous, active-high reset
iStart  input  1  request; sampled only in IDLE
iFunct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
iA  input  XLEN  operand rs1 / dividend
iB  input  XLEN  operand rs2 / divisor
oBusy  output  1  operation in progress
oDone  output  1  one-cycle pulse; oResult valid
oResult  output  XLEN  registered result; holds until the next oDone

Behaviour:
- Reset: the FSM goes to IDLE, and all outputs and internal registers are cleared. Asserting iRst mid-operation aborts the operation with no oDone.
- FSM states: IDLE, CALC, FIX.
- IDLE, iStart=1 at edge E0: latch iFunct3, the operand magnitudes and the sign flags.
  - Fast path: div-by-zero or signed overflow → FIX.
  - Otherwise → CALC, counter = XLEN.
- IDLE, iStart=0: stay in IDLE.
- CALC: one radix-2 step per edge; counter decrements; → FIX at the edge where the counter reaches 0.
- FIX, on the next edge: apply sign correction, select the result, register oResult, pulse oDone=1 for one cycle, → IDLE.
- Latency, counted in edges from the sampling edge E0 to the edge that raises oDone:
  - Iterative path: XLEN+1 (33 for XLEN=32).
  - Fast path: 1.
- oBusy = (state != IDLE). oBusy is low in the oDone cycle, and a new iStart is accepted in that same cycle.
- iStart while oBusy=1 is ignored. Operand and iFunct3 changes after E0 have no effect.
- Multiply:
  - Shift-add on magnitudes into a 2*XLEN accumulator.
  - Product negated iff the signed operand signs differ.
  - Signedness per op: MULH both operands signed; MULHSU A signed, B unsigned; MULHU/MUL both unsigned (MUL low half is sign-agnostic).
  - MUL returns product[XLEN-1:0]. MULH* return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes.
  - DIV quotient negated iff the signs differ. REM remainder takes the dividend's sign. DIVU/REMU are unsigned.
- Boundary cases, resolved on the fast path with no CALC:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - DIV/REM with dividend = most-negative and divisor = -1: DIV returns the dividend, REM returns 0.
- Dividend 0 and multiply by 0 use the normal iterative path.

Optional Feature:
Macro MULDIV_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU take the fast path. The full 2*XLEN signed/unsigned product is computed combinationally at E0 and latched into FIX. Multiply latency is 1. Divide behaviour is unchanged.
- Undefined: all multiplies are iterative, latency XLEN+1. No wide multiplier is inferred.

Test Plan:
- MUL iA=7, iB=0xFFFFFFFD (-3) → oResult=0xFFFFFFEB, oDone at edge E33. oBusy high from E0 to E33.
- Multiply high halves:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Signed divide:
  - DIV -7/2 → 0xFFFFFFFD.
  - REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Boundary cases (each → oDone at E1):
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Start DIV 100/7, then pulse iStart with MUL 3×3 at E5 → ignored; oResult=14 at E33. A MUL issued in the oDone cycle is accepted.
- Start DIV, assert iRst at E10 → oBusy=0, oDone=0, oResult=0 immediately. After release, MUL 6×7 → 42.
